sram_req_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the 32768x128 single-port SRAM macro.

- Round-robin arbitration grants the SRAM to one requester per access.
- Grants are either a single-beat byte-masked write or a 1-4 beat wrapping read burst.
- Read data is returned in order with valid/last flags.
- Sits between the instruction-side/data-side fetch logic and the SRAM macro (active-low CEN, active-low per-byte WEN, 1-cycle synchronous read).

---
 rtl/sram_req_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_sram_req_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port SRAM
// macro. Writes are single-beat byte-masked; reads are 1-4 beat bursts that
// wrap within the 4-word aligned block. Read data returns one cycle after
// each issued beat, flagged with valid/last on the owning port.

// Per-port response flags: one register stage tracks the SRAM read latency.
module sram_rsp_lane #(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  issue,
  input  logic                  last,
  input  logic [DATA_WIDTH-1:0] sram_q,
  output logic                  rsp_vld,
  output logic                  rsp_last,
  output logic [DATA_WIDTH-1:0] rsp_data
);

  // Flags follow the issued beat by one cycle; reset drops in-flight beats.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      rsp_vld  <= 1'b0;
      rsp_last <= 1'b0;
    end else begin
      rsp_vld  <= issue;
      rsp_last <= issue & last;
    end
  end

  assign rsp_data = sram_q;

endmodule

module sram_req_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 128
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    m0_req_vld,
  output logic                    m0_req_rdy,
  input  logic [ADDR_WIDTH-1:0]   m0_req_addr,
  input  logic                    m0_req_wr,
  input  logic [1:0]              m0_req_len,
  input  logic [DATA_WIDTH-1:0]   m0_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_req_wstrb,
  output logic                    m0_rsp_vld,
  output logic                    m0_rsp_last,
  output logic [DATA_WIDTH-1:0]   m0_rsp_data,
  input  logic                    m1_req_vld,
  output logic                    m1_req_rdy,
  input  logic [ADDR_WIDTH-1:0]   m1_req_addr,
  input  logic                    m1_req_wr,
  input  logic [1:0]              m1_req_len,
  input  logic [DATA_WIDTH-1:0]   m1_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_req_wstrb,
  output logic                    m1_rsp_vld,
  output logic                    m1_rsp_last,
  output logic [DATA_WIDTH-1:0]   m1_rsp_data,
  output logic [ADDR_WIDTH-1:0]   sram_a,
  output logic                    sram_cen,
  output logic [DATA_WIDTH/8-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0]   sram_d,
  input  logic [DATA_WIDTH-1:0]   sram_q
);

  localparam int NUM_PORTS = 2;
  localparam int STRB_W    = DATA_WIDTH / 8;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                                state, state_nxt;
  logic                                  prio, prio_nxt;
  logic                                  owner, owner_nxt;
  logic [ADDR_WIDTH-1:0]                 base, base_nxt;
  logic [1:0]                            beat, beat_nxt;
  logic [1:0]                            total, total_nxt;

  logic [NUM_PORTS-1:0]                  req_vld, req_wr, rdy;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_addr;
  logic [NUM_PORTS-1:0][1:0]             req_len;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_wdata;
  logic [NUM_PORTS-1:0][STRB_W-1:0]      req_wstrb;
  logic [NUM_PORTS-1:0]                  rd_issue, rd_last;
  logic [NUM_PORTS-1:0]                  rsp_vld, rsp_last;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rsp_data;
  logic                                  win;

  assign req_vld   = {m1_req_vld,   m0_req_vld};
  assign req_wr    = {m1_req_wr,    m0_req_wr};
  assign req_addr  = {m1_req_addr,  m0_req_addr};
  assign req_len   = {m1_req_len,   m0_req_len};
  assign req_wdata = {m1_req_wdata, m0_req_wdata};
  assign req_wstrb = {m1_req_wstrb, m0_req_wstrb};

  // A lone requester wins outright; a tie goes to the favoured port.
  assign win = (&req_vld) ? prio : req_vld[1];

  // Arbitration, SRAM drive and burst sequencing; reset masks every issue.
  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    owner_nxt = owner;
    base_nxt  = base;
    beat_nxt  = beat;
    total_nxt = total;
    rdy       = '0;
    rd_issue  = '0;
    rd_last   = '0;
    sram_cen  = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (rst_b) begin
      if (state == IDLE) begin
        if (|req_vld) begin
          rdy[win] = 1'b1;
          prio_nxt = ~win;
          if (req_wr[win]) begin
            // An all-zero strobe is accepted but touches nothing.
            if (|req_wstrb[win]) begin
              sram_cen = 1'b0;
              sram_a   = req_addr[win];
              sram_d   = req_wdata[win];
              sram_wen = ~req_wstrb[win];
            end
          end else begin
            sram_cen      = 1'b0;
            sram_a        = req_addr[win];
            rd_issue[win] = 1'b1;
            rd_last[win]  = (req_len[win] == 2'd0);
            if (req_len[win] != 2'd0) begin
              state_nxt = BURST;
              owner_nxt = win;
              base_nxt  = req_addr[win];
              beat_nxt  = 2'd1;
              total_nxt = req_len[win];
            end
          end
        end
      end else begin
        // Beat address wraps inside the 4-word aligned block.
        sram_cen        = 1'b0;
        sram_a          = {base[ADDR_WIDTH-1:2], 2'(base[1:0] + beat)};
        rd_issue[owner] = 1'b1;
        rd_last[owner]  = (beat == total);
        if (beat == total) state_nxt = IDLE;
        else               beat_nxt  = beat + 2'd1;
      end
    end
  end

  // Arbiter and burst state registers.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state <= IDLE;
      prio  <= 1'b0;
      owner <= 1'b0;
      base  <= '0;
      beat  <= '0;
      total <= '0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      owner <= owner_nxt;
      base  <= base_nxt;
      beat  <= beat_nxt;
      total <= total_nxt;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
    sram_rsp_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk      (clk),
      .rst_b    (rst_b),
      .issue    (rd_issue[p]),
      .last     (rd_last[p]),
      .sram_q   (sram_q),
      .rsp_vld  (rsp_vld[p]),
      .rsp_last (rsp_last[p]),
      .rsp_data (rsp_data[p])
    );
  end

  assign m0_req_rdy  = rdy[0];
  assign m1_req_rdy  = rdy[1];
  assign m0_rsp_vld  = rsp_vld[0];
  assign m1_rsp_vld  = rsp_vld[1];
  assign m0_rsp_last = rsp_last[0];
  assign m1_rsp_last = rsp_last[1];
  assign m0_rsp_data = rsp_data[0];
  assign m1_rsp_data = rsp_data[1];

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter with a behavioural SRAM macro model.
module tb_sram_req_arbiter;

  localparam int AW = 15;
  localparam int DW = 128;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          m0_req_vld, m0_req_rdy, m0_req_wr;
  logic [AW-1:0] m0_req_addr;
  logic [1:0]    m0_req_len;
  logic [DW-1:0] m0_req_wdata;
  logic [SW-1:0] m0_req_wstrb;
  logic          m0_rsp_vld, m0_rsp_last;
  logic [DW-1:0] m0_rsp_data;
  logic          m1_req_vld, m1_req_rdy, m1_req_wr;
  logic [AW-1:0] m1_req_addr;
  logic [1:0]    m1_req_len;
  logic [DW-1:0] m1_req_wdata;
  logic [SW-1:0] m1_req_wstrb;
  logic          m1_rsp_vld, m1_rsp_last;
  logic [DW-1:0] m1_rsp_data;
  logic [AW-1:0] sram_a;
  logic          sram_cen;
  logic [SW-1:0] sram_wen;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_b(rst_b),
    .m0_req_vld(m0_req_vld), .m0_req_rdy(m0_req_rdy), .m0_req_addr(m0_req_addr),
    .m0_req_wr(m0_req_wr), .m0_req_len(m0_req_len), .m0_req_wdata(m0_req_wdata),
    .m0_req_wstrb(m0_req_wstrb), .m0_rsp_vld(m0_rsp_vld), .m0_rsp_last(m0_rsp_last),
    .m0_rsp_data(m0_rsp_data),
    .m1_req_vld(m1_req_vld), .m1_req_rdy(m1_req_rdy), .m1_req_addr(m1_req_addr),
    .m1_req_wr(m1_req_wr), .m1_req_len(m1_req_len), .m1_req_wdata(m1_req_wdata),
    .m1_req_wstrb(m1_req_wstrb), .m1_rsp_vld(m1_rsp_vld), .m1_rsp_last(m1_rsp_last),
    .m1_rsp_data(m1_rsp_data),
    .sram_a(sram_a), .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_d(sram_d),
    .sram_q(sram_q)
  );

  // SRAM macro model: preloaded pattern, byte writes, 1-cycle read.
  logic [DW-1:0] mem [0:(1<<AW)-1];

  function automatic logic [DW-1:0] pat(input int i);
    logic [31:0] w;
    w = 32'hA5A50000 | 32'(i);
    return {4{w}};
  endfunction

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = pat(i);
    sram_q = '0;
  end

  always @(posedge clk) begin
    if (!sram_cen) begin
      for (int b = 0; b < SW; b++)
        if (!sram_wen[b]) mem[sram_a][b*8 +: 8] <= sram_d[b*8 +: 8];
      if (&sram_wen) sram_q <= mem[sram_a];
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; callers drive, then settle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req_vld = 0; m0_req_wr = 0; m0_req_addr = '0; m0_req_len = 0;
    m0_req_wdata = '0; m0_req_wstrb = '0;
    m1_req_vld = 0; m1_req_wr = 0; m1_req_addr = '0; m1_req_len = 0;
    m1_req_wdata = '0; m1_req_wstrb = '0;
  endtask

  localparam logic [DW-1:0] WPAT = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [DW-1:0] WEXP = {64'hA5A50010A5A50010, 64'h0706050403020100};

  initial begin
    rst_b = 0;
    idle_inputs();
    cyc(); cyc();
    // Reset holds outputs idle even with a request pending.
    m0_req_vld = 1;
    #2;
    chk("rst_m0_rdy", m0_req_rdy, 0);
    chk("rst_m1_rdy", m1_req_rdy, 0);
    chk("rst_cen", sram_cen, 1);
    chk("rst_wen", sram_wen, 16'hFFFF);
    chk("rst_a", sram_a, 0);
    chk("rst_d", sram_d, 0);
    chk("rst_m0_rsp_vld", m0_rsp_vld, 0);
    chk("rst_m1_rsp_vld", m1_rsp_vld, 0);
    chk("rst_m0_rsp_last", m0_rsp_last, 0);

    // Write then read back.
    cyc();
    rst_b = 1;
    m0_req_vld = 1; m0_req_wr = 1; m0_req_addr = 15'h0010;
    m0_req_wdata = WPAT; m0_req_wstrb = 16'h00FF;
    #2;
    chk("wr_m0_rdy", m0_req_rdy, 1);
    chk("wr_m1_rdy", m1_req_rdy, 0);
    chk("wr_cen", sram_cen, 0);
    chk("wr_wen", sram_wen, 16'hFF00);
    chk("wr_a", sram_a, 15'h0010);
    chk("wr_d", sram_d, WPAT);
    cyc();
    m0_req_wr = 0; m0_req_len = 0;
    #2;
    chk("rd_m0_rdy", m0_req_rdy, 1);
    chk("rd_cen", sram_cen, 0);
    chk("rd_wen", sram_wen, 16'hFFFF);
    chk("rd_a", sram_a, 15'h0010);
    cyc();
    idle_inputs();
    #2;
    chk("rd_rsp_vld", m0_rsp_vld, 1);
    chk("rd_rsp_last", m0_rsp_last, 1);
    chk("rd_rsp_data", m0_rsp_data, WEXP);
    chk("rd_m1_rsp_vld", m1_rsp_vld, 0);
    chk("rd_idle_cen", sram_cen, 1);

    // Wrapping burst on m1: 6,7,4,5.
    cyc();
    m1_req_vld = 1; m1_req_addr = 15'h0006; m1_req_len = 3;
    #2;
    chk("wrap_m1_rdy", m1_req_rdy, 1);
    chk("wrap_a0", sram_a, 15'h6);
    chk("wrap_cen0", sram_cen, 0);
    cyc();
    idle_inputs();
    #2;
    chk("wrap_a1", sram_a, 15'h7);
    chk("wrap_cen1", sram_cen, 0);
    chk("wrap_vld1", m1_rsp_vld, 1);
    chk("wrap_last1", m1_rsp_last, 0);
    chk("wrap_data1", m1_rsp_data, pat(6));
    cyc(); #2;
    chk("wrap_a2", sram_a, 15'h4);
    chk("wrap_vld2", m1_rsp_vld, 1);
    chk("wrap_last2", m1_rsp_last, 0);
    chk("wrap_data2", m1_rsp_data, pat(7));
    cyc(); #2;
    chk("wrap_a3", sram_a, 15'h5);
    chk("wrap_vld3", m1_rsp_vld, 1);
    chk("wrap_last3", m1_rsp_last, 0);
    chk("wrap_data3", m1_rsp_data, pat(4));
    cyc(); #2;
    chk("wrap_cen_end", sram_cen, 1);
    chk("wrap_vld4", m1_rsp_vld, 1);
    chk("wrap_last4", m1_rsp_last, 1);
    chk("wrap_data4", m1_rsp_data, pat(5));
    chk("wrap_m0_vld", m0_rsp_vld, 0);
    cyc(); #2;
    chk("wrap_vld5", m1_rsp_vld, 0);

    // Fair arbitration from reset.
    cyc();
    rst_b = 0;
    cyc();
    rst_b = 1;
    m0_req_vld = 1; m0_req_addr = 15'h0100;
    m1_req_vld = 1; m1_req_addr = 15'h0200;
    #2;
    chk("rr0_m0_rdy", m0_req_rdy, 1);
    chk("rr0_m1_rdy", m1_req_rdy, 0);
    chk("rr0_a", sram_a, 15'h0100);
    cyc(); #2;
    chk("rr1_m0_rdy", m0_req_rdy, 0);
    chk("rr1_m1_rdy", m1_req_rdy, 1);
    chk("rr1_a", sram_a, 15'h0200);
    chk("rr1_m0_rsp", m0_rsp_data, pat(16'h100));
    chk("rr1_m0_vld", m0_rsp_vld, 1);
    cyc(); #2;
    chk("rr2_m0_rdy", m0_req_rdy, 1);
    chk("rr2_m1_rdy", m1_req_rdy, 0);
    chk("rr2_cen", sram_cen, 0);
    chk("rr2_m1_vld", m1_rsp_vld, 1);
    chk("rr2_m0_vld", m0_rsp_vld, 0);
    chk("rr2_m1_rsp", m1_rsp_data, pat(16'h200));
    cyc(); #2;
    chk("rr3_m1_rdy", m1_req_rdy, 1);
    chk("rr3_m0_rdy", m0_req_rdy, 0);

    // Burst blocks the other port until T+4.
    cyc();
    idle_inputs();
    m0_req_vld = 1; m0_req_addr = 15'h0020; m0_req_len = 3;
    #2;
    chk("blk_t0_m0_rdy", m0_req_rdy, 1);
    chk("blk_t0_a", sram_a, 15'h0020);
    cyc();
    m0_req_vld = 0;
    m1_req_vld = 1; m1_req_addr = 15'h0030; m1_req_len = 0;
    #2;
    chk("blk_t1_m1_rdy", m1_req_rdy, 0);
    chk("blk_t1_a", sram_a, 15'h0021);
    cyc(); #2;
    chk("blk_t2_m1_rdy", m1_req_rdy, 0);
    chk("blk_t2_a", sram_a, 15'h0022);
    cyc(); #2;
    chk("blk_t3_m1_rdy", m1_req_rdy, 0);
    chk("blk_t3_a", sram_a, 15'h0023);
    cyc(); #2;
    chk("blk_t4_m1_rdy", m1_req_rdy, 1);
    chk("blk_t4_a", sram_a, 15'h0030);
    chk("blk_t4_m0_last", m0_rsp_last, 1);
    chk("blk_t4_m0_data", m0_rsp_data, pat(16'h23));
    cyc();
    idle_inputs();
    #2;
    chk("blk_t5_m1_vld", m1_rsp_vld, 1);
    chk("blk_t5_m1_last", m1_rsp_last, 1);
    chk("blk_t5_m1_data", m1_rsp_data, pat(16'h30));

    // Reset during beat 2 of a 4-beat read; prio was pointing at m1.
    cyc();
    m0_req_vld = 1; m0_req_addr = 15'h0040; m0_req_len = 3;
    #2;
    chk("rmb_r0_m0_rdy", m0_req_rdy, 1);
    cyc();
    m0_req_vld = 0;
    #2;
    chk("rmb_r1_a", sram_a, 15'h0041);
    cyc();
    rst_b = 0; m1_req_vld = 1;
    #2;
    chk("rmb_r2_cen", sram_cen, 1);
    chk("rmb_r2_m1_rdy", m1_req_rdy, 0);
    cyc(); #2;
    chk("rmb_r3_cen", sram_cen, 1);
    chk("rmb_r3_m0_vld", m0_rsp_vld, 0);
    chk("rmb_r3_m0_last", m0_rsp_last, 0);
    cyc();
    rst_b = 1;
    m0_req_vld = 1; m0_req_addr = 15'h0050; m0_req_len = 0;
    m1_req_vld = 1; m1_req_addr = 15'h0060; m1_req_len = 0;
    #2;
    chk("rmb_r4_m0_rdy", m0_req_rdy, 1);
    chk("rmb_r4_m1_rdy", m1_req_rdy, 0);
    chk("rmb_r4_a", sram_a, 15'h0050);
    chk("rmb_r4_m0_vld", m0_rsp_vld, 0);
    cyc();
    m0_req_vld = 0;
    #2;
    chk("rmb_r5_m1_rdy", m1_req_rdy, 1);
    chk("rmb_r5_a", sram_a, 15'h0060);
    chk("rmb_r5_m0_data", m0_rsp_data, pat(16'h50));
    cyc();
    idle_inputs();
    #2;
    chk("rmb_r6_m1_data", m1_rsp_data, pat(16'h60));

    // Zero-strobe write: accepted, no access, prio still flips.
    cyc();
    m0_req_vld = 1; m0_req_addr = 15'h0070; m0_req_len = 0;
    #2;
    chk("zs_pre_m0_rdy", m0_req_rdy, 1);
    cyc();
    m0_req_vld = 0;
    m1_req_vld = 1; m1_req_wr = 1; m1_req_addr = 15'h0010;
    m1_req_wdata = '1; m1_req_wstrb = '0;
    #2;
    chk("zs_m1_rdy", m1_req_rdy, 1);
    chk("zs_cen", sram_cen, 1);
    cyc();
    m1_req_wr = 0; m1_req_addr = 15'h0011; m1_req_wstrb = '0;
    m0_req_vld = 1; m0_req_addr = 15'h0010;
    #2;
    chk("zs_prio_m0_rdy", m0_req_rdy, 1);
    chk("zs_prio_m1_rdy", m1_req_rdy, 0);
    cyc();
    m0_req_vld = 0;
    #2;
    chk("zs_next_m1_rdy", m1_req_rdy, 1);
    chk("zs_mem_unchanged", m0_rsp_data, WEXP);
    cyc();
    idle_inputs();
    #2;
    chk("zs_m1_data", m1_rsp_data, pat(16'h11));
    chk("zs_end_cen", sram_cen, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
